// File: rtl/musb_uart_tx_pkg.sv
// Shared definitions for the MUSB UART transmit path.
// - tx_state_e : transmitter FSM state encoding, shared with the receive side and monitors.
// - DataBits   : payload width of one 8N1 frame.
// - calc_div() : rounded bus-clock cycles per bit, evaluated at elaboration time.
package musb_uart_tx_pkg;

  localparam int unsigned DataBits = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // Cycles per bit, rounded to nearest: (f_hz + baud/2) / baud.
  // 64-bit arithmetic so high bus frequencies cannot overflow the product.
  function automatic int unsigned calc_div(input int unsigned bus_freq_mhz,
                                           input int unsigned baud_rate);
    longint unsigned f_hz;
    longint unsigned baud;
    f_hz = 64'(bus_freq_mhz) * 64'd1_000_000;
    baud = 64'(baud_rate);
    return 32'((f_hz + baud / 64'd2) / baud);
  endfunction

endpackage

// File: rtl/musb_uart_tx_if.sv
// Bus-side handshake bundle of the UART transmitter.
// - tx_data  : byte to enqueue
// - tx_write : single-cycle enqueue strobe
// - tx_full  : FIFO full, writes ignored while high
// - tx_empty : FIFO holds no bytes
// - tx_busy  : frame in progress or FIFO non-empty
// master: register logic driving writes; slave: the transmitter.
interface musb_uart_tx_if;
  import musb_uart_tx_pkg::*;

  logic [DataBits-1:0] tx_data;
  logic                tx_write;
  logic                tx_full;
  logic                tx_empty;
  logic                tx_busy;

  modport master (
    output tx_data,
    output tx_write,
    input  tx_full,
    input  tx_empty,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_write,
    output tx_full,
    output tx_empty,
    output tx_busy
  );

endinterface

// File: rtl/musb_fifo.sv
// Synchronous show-ahead FIFO, reusable by the UART receive path.
// - clk, rst     : bus clock, asynchronous active-high reset (flushes the FIFO)
// - wr_i         : push strobe; ignored while full_o is high, even if a pop coincides
// - wr_data_i    : data pushed
// - rd_i         : pop strobe; ignored while empty_o is high
// - rd_data_o    : head entry, valid whenever empty_o is low
// - full_o       : registered, occupancy == depth
// - empty_o      : registered, occupancy == 0
module musb_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AddrWidth = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 rd_i,
  output logic [DataWidth-1:0] rd_data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned Depth = 1 << AddrWidth;
  localparam logic [AddrWidth:0] DepthCnt = (AddrWidth + 1)'(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]   count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 push, pop;

  // Qualified with the registered flags so a full FIFO never accepts a write.
  assign push = wr_i && !full_q;
  assign pop  = rd_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AddrWidth'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AddrWidth'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AddrWidth + 1)'(1);
      2'b01:   count_d = count_q - (AddrWidth + 1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/musb_uart_tx.sv
// UART transmitter: buffers bytes in a FIFO and serialises them as 8N1 frames.
// - clk, rst : bus clock, asynchronous active-high reset
// - bus      : slave side of the write handshake (tx_data/tx_write in, full/empty/busy out)
// - uart_tx  : registered serial line, idle high
// Each bit lasts DIV cycles; consecutive queued bytes go out with no idle gap.
module musb_uart_tx
  import musb_uart_tx_pkg::*;
#(
  parameter int unsigned BUS_FREQ        = 100,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_ADDR_WIDTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  musb_uart_tx_if.slave bus,
  output logic         uart_tx
);

  localparam int unsigned Div  = calc_div(BUS_FREQ, BAUD_RATE);
  localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(Div - 1);

  if (Div < 2) begin : g_div_check
    $error("musb_uart_tx: bit divisor must be at least 2");
  end

  tx_state_e             state_q, state_d;
  logic [CntW-1:0]       baud_q, baud_d;
  logic [DataBits-1:0]   shift_q, shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  bit_end;
  logic                  pop;
  logic [DataBits-1:0]   fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;

  musb_fifo #(
    .DataWidth (DataBits),
    .AddrWidth (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_i      (bus.tx_write),
    .wr_data_i (bus.tx_data),
    .rd_i      (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bit_end = (baud_q == '0);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_d = CntLoad;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end

      StStart: begin
        if (bit_end) begin
          baud_d    = CntLoad;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[DataBits-1:1]};
          bit_cnt_d = 3'd0;
          state_d   = StData;
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end

      StData: begin
        if (bit_end) begin
          baud_d = CntLoad;
          // bit_cnt_q is the index of the bit just finished.
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[DataBits-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end

      StStop: begin
        if (bit_end) begin
          baud_d = CntLoad;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end

      default: begin
        baud_d  = CntLoad;
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= CntLoad;
      shift_q   <= '0;
      bit_cnt_q <= 3'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  assign uart_tx      = tx_q;
  assign bus.tx_full  = fifo_full;
  assign bus.tx_empty = fifo_empty;
  assign bus.tx_busy  = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_musb_uart_tx.sv
// Directed bench for musb_uart_tx at DIV=8 (1 MHz bus, 125000 baud), FIFO depth 8.
// A line receiver decodes frames into rx_q; written bytes expected on the line go to exp_q.
module tb_musb_uart_tx;

  localparam int Div = 8;
  localparam int FrameCycles = 10 * Div;

  logic clk;
  logic rst;
  logic uart_tx;

  musb_uart_tx_if bus ();

  musb_uart_tx #(
    .BUS_FREQ        (1),
    .BAUD_RATE       (125000),
    .FIFO_ADDR_WIDTH (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Line receiver: samples mid-bit on falling clock edges, drops frames cut by reset.
  initial begin : rx_monitor
    logic       prev;
    logic       aborted;
    logic [7:0] data;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev === 1'b1 && uart_tx === 1'b0) begin
        aborted = 1'b0;
        data    = 8'h00;
        for (int i = 1; i <= 76; i++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          if (!aborted) begin
            if (i == Div / 2) chk1("rx_start_bit", uart_tx, 1'b0);
            if (i > Div && i < 9 * Div && (i % Div) == Div / 2)
              data[(i / Div) - 1] = uart_tx;
            if (i == 76) chk1("rx_stop_bit", uart_tx, 1'b1);
          end
        end
        if (!aborted) rx_q.push_back(data);
        prev = 1'b1;
      end else begin
        prev = uart_tx;
      end
    end
  end

  task automatic sb_check(input string tag);
    while (exp_q.size() > 0) begin
      if (rx_q.size() == 0) begin
        chki({tag, "_rx_count"}, 0, exp_q.size());
        exp_q.delete();
      end else begin
        chk8(tag, rx_q.pop_front(), exp_q.pop_front());
      end
    end
    chki({tag, "_rx_extra"}, rx_q.size(), 0);
    rx_q.delete();
  endtask

  // Called on the first falling edge of the start bit; checks every cycle of the frame.
  task automatic run_frame(input logic [7:0] b, input string tag);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < FrameCycles; i++) begin
      chk1({tag, "_line"}, uart_tx, fr[i / Div]);
      chk1({tag, "_busy"}, bus.tx_busy, 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chki("idle_within_budget", (n < budget) ? 1 : 0, 1);
  endtask

  initial begin : main
    logic [9:0] frs [3];

    rst          = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_write = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    chk1("rst_uart_tx", uart_tx, 1'b1);
    chk1("rst_empty", bus.tx_empty, 1'b1);
    chk1("rst_full", bus.tx_full, 1'b0);
    chk1("rst_busy", bus.tx_busy, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk1("idle_line", uart_tx, 1'b1);
    end
    chk1("idle_busy", bus.tx_busy, 1'b0);

    // Single byte 0x55
    bus.tx_data = 8'h55; bus.tx_write = 1'b1; exp_q.push_back(8'h55);
    @(negedge clk);
    bus.tx_write = 1'b0;
    chk1("single_busy_at_write", bus.tx_busy, 1'b1);
    chk1("single_empty_at_write", bus.tx_empty, 1'b0);
    chk1("single_line_before_pop", uart_tx, 1'b1);
    @(negedge clk);
    chk1("single_empty_after_pop", bus.tx_empty, 1'b1);
    run_frame(8'h55, "single");
    chk1("single_busy_fall", bus.tx_busy, 1'b0);
    chk1("single_line_idle", uart_tx, 1'b1);
    sb_check("single_rx");

    // Back-to-back 0xA5, 0x3C
    repeat (5) @(negedge clk);
    bus.tx_data = 8'hA5; bus.tx_write = 1'b1; exp_q.push_back(8'hA5);
    @(negedge clk);
    bus.tx_data = 8'h3C; bus.tx_write = 1'b1; exp_q.push_back(8'h3C);
    chk1("b2b_busy", bus.tx_busy, 1'b1);
    @(negedge clk);
    bus.tx_write = 1'b0;
    chk1("b2b_empty_pushpop", bus.tx_empty, 1'b0);
    run_frame(8'hA5, "b2b_first");
    run_frame(8'h3C, "b2b_second");
    chk1("b2b_busy_fall", bus.tx_busy, 1'b0);
    sb_check("b2b_rx");

    // Full and overflow: 0x00..0x09, the tenth write is dropped
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk1("ovf_full_after_9", bus.tx_full, 1'b1);
      bus.tx_data  = 8'(i);
      bus.tx_write = 1'b1;
      if (i < 9) exp_q.push_back(8'(i));
      @(negedge clk);
    end
    bus.tx_write = 1'b0;
    chk1("ovf_full_after_10", bus.tx_full, 1'b1);
    wait_idle(12 * FrameCycles);
    chk1("ovf_empty_end", bus.tx_empty, 1'b1);
    chk1("ovf_full_end", bus.tx_full, 1'b0);
    sb_check("ovf_rx");

    // Push/pop coincidence on the STOP pop
    repeat (5) @(negedge clk);
    frs[0] = {1'b1, 8'h81, 1'b0};
    frs[1] = {1'b1, 8'h42, 1'b0};
    frs[2] = {1'b1, 8'hE7, 1'b0};
    bus.tx_data = 8'h81; bus.tx_write = 1'b1; exp_q.push_back(8'h81);
    @(negedge clk);
    bus.tx_write = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3 * FrameCycles; i++) begin
      chk1("coin_line", uart_tx, frs[i / FrameCycles][(i % FrameCycles) / Div]);
      if (i == 0) begin
        bus.tx_data = 8'h42; bus.tx_write = 1'b1; exp_q.push_back(8'h42);
      end
      if (i == 1) bus.tx_write = 1'b0;
      if (i == FrameCycles - 1) begin
        bus.tx_data = 8'hE7; bus.tx_write = 1'b1; exp_q.push_back(8'hE7);
      end
      if (i == FrameCycles) begin
        bus.tx_write = 1'b0;
        chk1("coin_empty_after_pushpop", bus.tx_empty, 1'b0);
        chk1("coin_full_after_pushpop", bus.tx_full, 1'b0);
      end
      if (i == 2 * FrameCycles) chk1("coin_empty_last_pop", bus.tx_empty, 1'b1);
      @(negedge clk);
    end
    chk1("coin_busy_fall", bus.tx_busy, 1'b0);
    sb_check("coin_rx");

    // Reset mid-frame during data bit 3
    repeat (5) @(negedge clk);
    bus.tx_data = 8'h00; bus.tx_write = 1'b1;
    @(negedge clk);
    bus.tx_write = 1'b0;
    @(negedge clk);
    repeat (4 * Div + 2) @(negedge clk);
    chk1("midrst_line_before", uart_tx, 1'b0);
    rst = 1'b1;
    #1;
    chk1("midrst_line_async", uart_tx, 1'b1);
    chk1("midrst_busy", bus.tx_busy, 1'b0);
    chk1("midrst_empty", bus.tx_empty, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk1("midrst_line_idle", uart_tx, 1'b1);
    end
    chk1("midrst_busy_idle", bus.tx_busy, 1'b0);
    sb_check("midrst_rx");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
